// File: rtl/force_override_ctrl_if.sv
// Request channel for the force override controller: valid/ready handshake
// carrying the force polarity and hold duration.
interface force_override_ctrl_if #(
  parameter int HOLD_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_value;
  logic [HOLD_W-1:0] req_hold;

  modport master (
    output req_valid,
    output req_value,
    output req_hold,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_value,
    input  req_hold,
    output req_ready
  );
endinterface

// File: rtl/force_override_ctrl.sv
// Issuer of force-set / force-clear overrides: holds one force line for a
// requested number of cycles, then enforces a guard gap. Optional FORCE_COUNT_EN adds counters.
module force_override_ctrl #(
  parameter int HOLD_W       = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  force_override_ctrl_if.slave  req,
  input  logic                  abort,
  output logic                  force_set,
  output logic                  force_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  last_value
`ifdef FORCE_COUNT_EN
  ,
  output logic [7:0]            done_cnt,
  output logic [7:0]            abort_cnt
`endif
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GUARD
  } state_t;

  state_t              state;
  state_t              state_nxt;
  state_t              exit_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [GUARD_W-1:0]  guard_cnt;
  logic [GUARD_W-1:0]  guard_nxt;
  logic [GUARD_W-1:0]  guard_load;
  logic                set_nxt;
  logic                rst_nxt;
  logic                done_nxt;
  logic                aborted_nxt;
  logic                last_nxt;

  // A zero-length guard skips the GUARD state entirely.
  assign exit_state    = (GUARD_CYCLES == 0) ? IDLE : GUARD;
  assign guard_load    = GUARD_W'(GUARD_CYCLES);
  assign req.req_ready = (state == IDLE) && rst_n;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    guard_nxt   = guard_cnt;
    set_nxt     = 1'b0;
    rst_nxt     = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    last_nxt    = last_value;
    case (state)
      IDLE: begin
        if (req.req_valid && req.req_ready) begin
          state_nxt = ASSERT;
          last_nxt  = req.req_value;
          hold_nxt  = (req.req_hold == '0) ? HOLD_W'(1) : req.req_hold;
          set_nxt   = req.req_value;
          rst_nxt   = ~req.req_value;
        end
      end
      ASSERT: begin
        // Abort takes priority over a hold that would otherwise expire now.
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = exit_state;
          guard_nxt   = guard_load;
        end else if (hold_cnt <= HOLD_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = exit_state;
          guard_nxt = guard_load;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
          set_nxt  = force_set;
          rst_nxt  = force_rst;
        end
      end
      GUARD: begin
        if (guard_cnt <= GUARD_W'(1)) begin
          state_nxt = IDLE;
        end else begin
          guard_nxt = guard_cnt - GUARD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      guard_cnt <= guard_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_set  <= 1'b0;
      force_rst  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      last_value <= 1'b0;
    end else begin
      force_set  <= set_nxt;
      force_rst  <= rst_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      last_value <= last_nxt;
    end
  end

`ifdef FORCE_COUNT_EN
  // Counters advance on the edge their pulse asserts and stick at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt  <= 8'd0;
      abort_cnt <= 8'd0;
    end else begin
      if (done_nxt && (done_cnt != 8'hFF)) begin
        done_cnt <= done_cnt + 8'd1;
      end
      if (aborted_nxt && (abort_cnt != 8'hFF)) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
